// File: rtl/fifo_param_ctrl_if.sv
`default_nettype none
// ============================================================================
// fifo_param_ctrl_if : write/read handshake, thresholds and status of the FIFO
// Rev 1.0 - initial release
// ============================================================================
interface fifo_param_ctrl_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
);
  logic                  wr_enable;
  logic                  rd_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH:0]   afull_thresh;
  logic [ADDR_WIDTH:0]   aempty_thresh;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  full_fifo;
  logic                  empty_fifo;
  logic                  almost_full_fifo;
  logic                  almost_empty_fifo;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output wr_enable, rd_enable, data_in, afull_thresh, aempty_thresh,
    input  data_out, data_out_valid, fifo_count, full_fifo, empty_fifo,
           almost_full_fifo, almost_empty_fifo, overflow_err, underflow_err
  );

  modport slave (
    input  wr_enable, rd_enable, data_in, afull_thresh, aempty_thresh,
    output data_out, data_out_valid, fifo_count, full_fifo, empty_fifo,
           almost_full_fifo, almost_empty_fifo, overflow_err, underflow_err
  );
endinterface
`default_nettype wire

// File: rtl/fifo_param_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_param_ctrl : synchronous FIFO with run-time thresholds, sticky errors
// Rev 1.0 - initial release
// ============================================================================
module fifo_param_ctrl #(
  parameter int DATA_WIDTH  = 6,
  parameter int ADDR_WIDTH  = 2,
  parameter int HOLD_OUTPUT = 0
) (
  input  wire              clk,
  input  wire              reset,
  fifo_param_ctrl_if.slave bus
);
  localparam int                  c_depth     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth_cnt = (ADDR_WIDTH + 1)'(c_depth);
  localparam logic [ADDR_WIDTH:0] c_cnt_one   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth_cnt);
  assign w_rd_ok = bus.rd_enable & ~w_empty;
  // A write at full is only safe when a read frees the slot in the same edge
  assign w_wr_ok = bus.wr_enable & (~w_full | w_rd_ok);

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_ok) begin
        r_rd_ptr     <= r_rd_ptr + c_ptr_one;
        r_data_out   <= r_mem[r_rd_ptr];
        r_data_valid <= 1'b1;
      end else begin
        r_data_valid <= 1'b0;
        if (HOLD_OUTPUT == 0) begin
          r_data_out <= '0;
        end
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (bus.wr_enable && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_enable && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.data_out          = r_data_out;
  assign bus.data_out_valid    = r_data_valid;
  assign bus.fifo_count        = r_count;
  assign bus.full_fifo         = w_full;
  assign bus.empty_fifo        = w_empty;
  assign bus.almost_full_fifo  = (r_count >= bus.afull_thresh);
  assign bus.almost_empty_fifo = (r_count <= bus.aempty_thresh);
  assign bus.overflow_err      = r_overflow;
  assign bus.underflow_err     = r_underflow;
endmodule
`default_nettype wire
